// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-time program loader.
// Optional feature macro: PROG_LOADER_CHECKSUM_EN (adds the CHECK state and payload XOR).
package prog_loader_pkg;

  // Width of the big-endian word-count field at the head of the stream.
  localparam int unsigned LenWidth = 16;
  // Instruction word width written to instruction memory.
  localparam int unsigned InstrWidth = 32;

  typedef enum logic [2:0] {
    StLenHi = 3'd0,
    StLenLo = 3'd1,
    StData  = 3'd2,
    StWrite = 3'd3,
`ifdef PROG_LOADER_CHECKSUM_EN
    StCheck = 3'd4,
`endif
    StRun   = 3'd5,
    StErr   = 3'd6
  } ldr_state_e;

  // States in which the loader takes a byte from the stream.
  function automatic logic accepts_bytes(input ldr_state_e st);
    case (st)
      StLenHi, StLenLo, StData: accepts_bytes = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
      StCheck: accepts_bytes = 1'b1;
`endif
      default: accepts_bytes = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ldr_word_assembler.sv
// Packs accepted stream bytes MSB-first into 32-bit instruction words.
// Optional feature macro: PROG_LOADER_CHECKSUM_EN (no effect in this file).
module ldr_word_assembler
  import prog_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic [InstrWidth-1:0] word,
  output logic                  word_ready
);

  logic [1:0]            idx_q, idx_d;
  logic [InstrWidth-1:0] word_q, word_d;

  // Next byte index and shifted word; clr drops any partial word.
  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clr) begin
      idx_d  = 2'd0;
      word_d = '0;
    end else if (byte_valid) begin
      idx_d  = idx_q + 2'd1;
      word_d = {word_q[InstrWidth-9:0], byte_data};
    end
  end

  // Byte index and shift register state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q  <= 2'd0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  assign word       = word_q;
  // Fourth byte of a word is being accepted this cycle.
  assign word_ready = byte_valid && !clr && (idx_q == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: receives a length-prefixed byte stream, writes big-endian
// instruction words to imem from address 0, then releases the core from reset.
// Optional feature macro: PROG_LOADER_CHECKSUM_EN (trailing XOR checksum byte).
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  input  logic                  start,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [InstrWidth-1:0] imem_wdata,
  output logic                  core_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam int unsigned CntW = LenWidth + 1;
  localparam logic [CntW-1:0] Capacity = CntW'(1) << ADDR_WIDTH;

  ldr_state_e            state_q, state_d;
  logic [7:0]            len_hi_q, len_hi_d;
  logic [LenWidth-1:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
  logic [LenWidth-1:0]   len_n;
  logic [CntW-1:0]       count_next;
  logic                  accept;
  logic                  restart;
  logic                  asm_clr;
  logic                  asm_valid;
  logic [InstrWidth-1:0] asm_word;
  logic                  asm_word_ready;
  ldr_state_e            st_after_load;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
  assign st_after_load = StCheck;
`else
  assign st_after_load = StRun;
`endif

  assign rx_ready   = accepts_bytes(state_q);
  assign accept     = rx_valid && rx_ready;
  assign restart    = start && ((state_q == StRun) || (state_q == StErr));
  assign len_n      = {len_hi_q, rx_data};
  assign count_next = CntW'(word_count_q) + CntW'(1);

  // The length phase and a restart both begin a fresh word.
  assign asm_clr   = restart || (state_q == StLenHi) || (state_q == StLenLo);
  assign asm_valid = accept && (state_q == StData);

  ldr_word_assembler u_word_assembler (
    .clk        (clk),
    .rst        (rst),
    .clr        (asm_clr),
    .byte_valid (asm_valid),
    .byte_data  (rx_data),
    .word       (asm_word),
    .word_ready (asm_word_ready)
  );

  // Next-state and datapath updates for the load sequence.
  always_comb begin
    state_d      = state_q;
    len_hi_d     = len_hi_q;
    len_d        = len_q;
    word_count_d = word_count_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    case (state_q)
      StLenHi: begin
`ifdef PROG_LOADER_CHECKSUM_EN
        csum_d = 8'h00;
`endif
        if (accept) begin
          len_hi_d = rx_data;
          state_d  = StLenLo;
        end
      end
      StLenLo: begin
        if (accept) begin
          len_d = len_n;
          if (len_n == '0) begin
            state_d = st_after_load;
          end else if ({1'b0, len_n} > Capacity) begin
            state_d = StErr;
          end else begin
            state_d      = StData;
            word_count_d = '0;
          end
        end
      end
      StData: begin
`ifdef PROG_LOADER_CHECKSUM_EN
        if (accept) csum_d = csum_q ^ rx_data;
`endif
        if (asm_word_ready) state_d = StWrite;
      end
      StWrite: begin
        word_count_d = word_count_q + 1'b1;
        state_d      = (count_next == {1'b0, len_q}) ? st_after_load : StData;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      StCheck: begin
        if (accept) state_d = (rx_data == csum_q) ? StRun : StErr;
      end
`endif
      StRun, StErr: begin
        if (start) begin
          state_d      = StLenHi;
          word_count_d = '0;
        end
      end
      default: state_d = StLenHi;
    endcase
  end

  // State and datapath registers; reset discards any load in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StLenHi;
      len_hi_q     <= 8'h00;
      len_q        <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      len_hi_q     <= len_hi_d;
      len_q        <= len_d;
      word_count_q <= word_count_d;
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  // Running XOR of payload bytes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) csum_q <= 8'h00;
    else      csum_q <= csum_d;
  end
`endif

  assign imem_we    = (state_q == StWrite);
  assign imem_addr  = word_count_q[ADDR_WIDTH-1:0];
  assign imem_wdata = asm_word;
  assign core_rst   = (state_q == StRun);
  assign done       = (state_q == StRun);
  assign error      = (state_q == StErr);
  assign busy       = (state_q != StRun) && (state_q != StErr);
  assign word_count = word_count_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader (ADDR_WIDTH=4). Honors PROG_LOADER_CHECKSUM_EN.
module tb_prog_loader;

  localparam int unsigned AW = 4;
  localparam int Cap = 1 << AW;

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          start;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW:0]   word_count;

  prog_loader #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .start      (start),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model state: expected writes and expected end-of-load status.
  logic [AW-1:0] exp_addr[$];
  logic [31:0]   exp_data[$];
  int            exp_done, exp_err, exp_wc;
  // Observed writes.
  logic [AW-1:0] log_addr[$];
  logic [31:0]   log_data[$];
  int            last_we_cyc = 0;
  int            rise_cyc = -100;
  logic          core_rst_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected behaviour derived from the stream contents alone.
  function automatic void model_load(input bq_t s);
    int n;
    logic [7:0] cs;
    logic [31:0] w;
    n = int'({s[0], s[1]});
    exp_done = 0;
    exp_err = 0;
    exp_wc = 0;
    cs = 8'h00;
    if (n > Cap) begin
      exp_err = 1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      if (s.size() < 2 + 4 * i + 4) return;
      w = {s[2+4*i], s[3+4*i], s[4+4*i], s[5+4*i]};
      cs = cs ^ s[2+4*i] ^ s[3+4*i] ^ s[4+4*i] ^ s[5+4*i];
      exp_addr.push_back(AW'(i));
      exp_data.push_back(w);
      exp_wc++;
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    if (s.size() < 2 + 4 * n + 1) return;
    if (s[2+4*n] == cs) exp_done = 1;
    else exp_err = 1;
`else
    exp_done = 1;
`endif
  endfunction

  function automatic bq_t with_cs(input bq_t s);
    bq_t r;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] x;
`endif
    r = s;
`ifdef PROG_LOADER_CHECKSUM_EN
    x = 8'h00;
    for (int i = 2; i < s.size(); i++) x = x ^ s[i];
    r.push_back(x);
`endif
    return r;
  endfunction

  always @(posedge clk) cyc++;

  // Compare process: every cycle out of reset.
  always @(negedge clk) begin
    if (rst) begin
      check("busy_vs_flags", {31'b0, busy}, {31'b0, !(done || error)});
      check("core_rst_vs_done", {31'b0, core_rst}, {31'b0, done});
      check("ready_when_idle", {31'b0, rx_ready && (done || error)}, 32'd0);
      if (imem_we) begin
        log_addr.push_back(imem_addr);
        log_data.push_back(imem_wdata);
        last_we_cyc = cyc;
        if (exp_addr.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected",
                   imem_addr, imem_wdata);
        end else begin
          check("wr_addr", {28'b0, imem_addr}, {28'b0, exp_addr.pop_front()});
          check("wr_data", imem_wdata, exp_data.pop_front());
        end
      end
      if (core_rst && !core_rst_prev) rise_cyc = cyc;
    end
    core_rst_prev = core_rst;
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (1) begin
      @(negedge clk);
      if (rx_ready) break;
      n++;
      if (n > 100) begin
        check("send_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_stream(input bq_t s, input int gap_at, input int gap_len);
    for (int i = 0; i < s.size(); i++) begin
      if (i == gap_at) begin
        rx_valid = 1'b0;
        repeat (gap_len) @(posedge clk);
        #1;
      end
      send_byte(s[i]);
    end
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(done || error)) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        check("end_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic check_end(input string tag);
    check({tag, "_done"}, {31'b0, done}, 32'(exp_done));
    check({tag, "_error"}, {31'b0, error}, 32'(exp_err));
    check({tag, "_core_rst"}, {31'b0, core_rst}, 32'(exp_done));
    check({tag, "_word_count"}, {27'b0, word_count}, 32'(exp_wc));
    check({tag, "_pending_writes"}, 32'(exp_addr.size()), 32'd0);
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    bq_t s;
    rst = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state.
    check("rst_rx_ready", {31'b0, rx_ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd1);
    check("rst_core_rst", {31'b0, core_rst}, 32'd0);
    check("rst_we", {31'b0, imem_we}, 32'd0);
    check("rst_word_count", {27'b0, word_count}, 32'd0);
    rst = 1'b1;

    // 1: two words, back-to-back bytes.
    s = with_cs('{8'h00, 8'h02, 8'h24, 8'h01, 8'h00, 8'h05, 8'h08, 8'h00, 8'h00, 8'h10});
    log_addr.delete();
    log_data.delete();
    rise_cyc = -100;
    model_load(s);
    send_stream(s, -1, 0);
    wait_end();
    check_end("t1");
    check("t1_word0", log_data[0], 32'h24010005);
    check("t1_word1", log_data[1], 32'h08000010);
    check("t1_addr1", {28'b0, log_addr[1]}, 32'd1);
`ifdef PROG_LOADER_CHECKSUM_EN
    check("t1_release_latency", 32'(rise_cyc - last_we_cyc), 32'd2);
`else
    check("t1_release_latency", 32'(rise_cyc - last_we_cyc), 32'd1);
`endif

    // 2: same stream with a 3-cycle valid gap inside the first word.
    pulse_start();
    check("t2_restart_done", {31'b0, done}, 32'd0);
    check("t2_restart_count", {27'b0, word_count}, 32'd0);
    log_addr.delete();
    log_data.delete();
    model_load(s);
    send_stream(s, 4, 3);
    wait_end();
    check_end("t2");
    check("t2_write_count", 32'(log_data.size()), 32'd2);

    // 3a: length 17 exceeds capacity 16.
    pulse_start();
    log_addr.delete();
    log_data.delete();
    s = '{8'h00, 8'h11};
    model_load(s);
    send_stream(s, -1, 0);
    wait_end();
    check_end("t3a");
    check("t3a_error_lit", {31'b0, error}, 32'd1);
    check("t3a_no_writes", 32'(log_data.size()), 32'd0);
    pulse_start();
    check("t3a_restart_error", {31'b0, error}, 32'd0);
    check("t3a_restart_ready", {31'b0, rx_ready}, 32'd1);

    // 3b: full capacity, 16 words.
    s = '{8'h00, 8'h10};
    for (int i = 0; i < 64; i++) s.push_back(8'(i * 7 + 3));
    s = with_cs(s);
    log_addr.delete();
    log_data.delete();
    model_load(s);
    send_stream(s, -1, 0);
    wait_end();
    check_end("t3b");
    check("t3b_last_addr", {28'b0, log_addr[15]}, 32'd15);
    check("t3b_word_count_lit", {27'b0, word_count}, 32'd16);
    check("t3b_word0_lit", log_data[0], 32'h030a1118);

    // 4: start and rx_valid together in RUN, then a zero-length image.
    log_addr.delete();
    log_data.delete();
    s = with_cs('{8'h00, 8'h00});
    model_load(s);
    @(posedge clk);
    #1;
    rx_valid = 1'b1;
    rx_data = 8'h00;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("t4_restart_busy", {31'b0, busy}, 32'd1);
    check("t4_restart_ready", {31'b0, rx_ready}, 32'd1);
    send_byte(8'h00);
    for (int i = 1; i < s.size(); i++) send_byte(s[i]);
    wait_end();
    check_end("t4");
    check("t4_no_writes", 32'(log_data.size()), 32'd0);

    // 5: reset after 6 payload bytes, then a fresh one-word image.
    pulse_start();
    log_addr.delete();
    log_data.delete();
    s = '{8'h00, 8'h02, 8'h24, 8'h01, 8'h00, 8'h05, 8'h08, 8'h00};
    model_load(s);
    send_stream(s, -1, 0);
    rst = 1'b0;
    #1;
    check("t5_rst_we", {31'b0, imem_we}, 32'd0);
    check("t5_rst_addr", {28'b0, imem_addr}, 32'd0);
    check("t5_rst_wdata", imem_wdata, 32'd0);
    check("t5_rst_count", {27'b0, word_count}, 32'd0);
    check("t5_rst_busy", {31'b0, busy}, 32'd1);
    check("t5_rst_flags", {29'b0, core_rst, done, error}, 32'd0);
    check("t5_partial_writes", 32'(log_data.size()), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    log_addr.delete();
    log_data.delete();
    s = with_cs('{8'h00, 8'h01, 8'hde, 8'had, 8'hbe, 8'hef});
    model_load(s);
    send_stream(s, -1, 0);
    wait_end();
    check_end("t5");
    check("t5_word_lit", log_data[0], 32'hdeadbeef);

`ifdef PROG_LOADER_CHECKSUM_EN
    // 6: correct words, wrong checksum.
    pulse_start();
    log_addr.delete();
    log_data.delete();
    s = '{8'h00, 8'h02, 8'h24, 8'h01, 8'h00, 8'h05, 8'h08, 8'h00, 8'h00, 8'h10, 8'h00};
    model_load(s);
    send_stream(s, -1, 0);
    wait_end();
    check_end("t6");
    check("t6_error_lit", {31'b0, error}, 32'd1);
    check("t6_writes_kept", 32'(log_data.size()), 32'd2);
    pulse_start();
    check("t6_restart_ready", {31'b0, rx_ready}, 32'd1);
    check("t6_restart_error", {31'b0, error}, 32'd0);
`endif

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
